twos_comp_serial: RTL and testbench

TWOS_COMP_SERIAL -- requirements
Module: twos_comp_serial

---
 rtl/twos_comp_serial.sv | 163 ++++++++++++++++
 tb/tb_twos_comp_serial.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_comp_serial.sv
// Digit-serial two's-complement unit: pass, negate, absolute value or ones' complement,
// DIGIT bits per cycle. Define TWOS_COMP_SATURATE_EN to clamp overflowing results to max positive.
module twos_comp_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(NDIG - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_alive;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_cnt;
    logic             r_invert;
    logic             r_carry;
    logic             r_ovf_pend;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_inv;
    logic             w_cin;
    logic             w_ovf_case;
    logic [DIGIT-1:0] w_digit;
    logic [DIGIT:0]   w_sum;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_final;

    assign w_accept = in_ready & in_valid;
    assign w_last   = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // Operation is reduced to "optionally invert, then add a carry-in" once at accept.
    always_comb begin
        w_inv = 1'b0;
        w_cin = 1'b0;
        case (mode)
            2'b01: begin
                w_inv = 1'b1;
                w_cin = 1'b1;
            end
            2'b10: begin
                w_inv = in_data[WIDTH-1];
                w_cin = in_data[WIDTH-1];
            end
            2'b11: begin
                w_inv = 1'b1;
                w_cin = 1'b0;
            end
            default: begin
                w_inv = 1'b0;
                w_cin = 1'b0;
            end
        endcase
    end

    assign w_ovf_case = ((mode == 2'b01) || (mode == 2'b10)) && (in_data == MIN_NEG);

    assign w_digit      = r_shift[DIGIT-1:0] ^ {DIGIT{r_invert}};
    assign w_sum        = {1'b0, w_digit} + {{DIGIT{1'b0}}, r_carry};
    assign w_shift_next = r_shift >> DIGIT;

    generate
        if (NDIG == 1) begin : g_single_digit
            assign w_res_next = w_sum[DIGIT-1:0];
        end else begin : g_multi_digit
            assign w_res_next = {w_sum[DIGIT-1:0], r_result[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef TWOS_COMP_SATURATE_EN
    assign w_final = r_ovf_pend ? MAX_POS : w_res_next;
`else
    assign w_final = w_res_next;
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = r_alive && (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_result   <= '0;
            r_out_data <= '0;
            r_cnt      <= '0;
            r_invert   <= 1'b0;
            r_carry    <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_accept) begin
            r_shift    <= in_data;
            r_result   <= '0;
            r_cnt      <= '0;
            r_invert   <= w_inv;
            r_carry    <= w_cin;
            r_ovf_pend <= w_ovf_case;
        end else if (r_state == S_RUN) begin
            r_shift  <= w_shift_next;
            r_result <= w_res_next;
            r_carry  <= w_sum[DIGIT];
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_out_data <= w_final;
                r_ovf      <= r_ovf_pend;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            r_ovf <= 1'b0;
        end
    end

    assign out_data = r_out_data;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Scoreboard bench for twos_comp_serial: 8-bit/1-bit-digit and 16-bit/4-bit-digit instances.
module tb_twos_comp_serial;

    localparam int WA = 8;
    localparam int NA = 8;
    localparam int WB = 16;
    localparam int NB = 4;

`ifdef TWOS_COMP_SATURATE_EN
    localparam logic [WA-1:0] A_MINRES = 8'h7F;
    localparam logic [WB-1:0] B_MINRES = 16'h7FFF;
`else
    localparam logic [WA-1:0] A_MINRES = 8'h80;
    localparam logic [WB-1:0] B_MINRES = 16'h8000;
`endif

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        int          due;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_ovf;
    logic [WA-1:0] a_in_data = '0, a_out_data;
    logic [1:0]    a_mode = 2'b00;
    logic          b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_ovf;
    logic [WB-1:0] b_in_data = '0, b_out_data;
    logic [1:0]    b_mode = 2'b00;

    twos_comp_serial #(.WIDTH(WA), .DIGIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .ovf(a_ovf)
    );

    twos_comp_serial #(.WIDTH(WB), .DIGIT(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .ovf(b_ovf)
    );

    int   n_pass = 0;
    int   n_chk  = 0;
    int   cyc    = 0;
    exp_t qa[$];
    exp_t qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endfunction

    // Monitor for instance A
    bit            a_seen = 1'b0;
    logic [WA-1:0] a_hold;
    logic          a_hold_ovf;
    always @(negedge clk) begin
        exp_t e;
        if (a_out_valid) begin
            check("a_ready_while_valid", a_in_ready, 1'b0);
            if (!a_seen) begin
                check("a_result_expected", qa.size() != 0, 1'b1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check({e.tag, "_data"}, a_out_data, e.data);
                    check({e.tag, "_ovf"}, a_ovf, e.ovf);
                    check({e.tag, "_latency"}, cyc, e.due);
                    $display("A %s: out_data=%0h ovf=%0b cycle=%0d", e.tag, a_out_data, a_ovf, cyc);
                end
                a_seen     = 1'b1;
                a_hold     = a_out_data;
                a_hold_ovf = a_ovf;
            end else begin
                check("a_hold_data", a_out_data, a_hold);
                check("a_hold_ovf", a_ovf, a_hold_ovf);
            end
            if (a_out_ready) a_seen = 1'b0;
        end
    end

    // Monitor for instance B
    bit b_seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (b_out_valid) begin
            if (!b_seen) begin
                check("b_result_expected", qb.size() != 0, 1'b1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check({e.tag, "_data"}, b_out_data, e.data);
                    check({e.tag, "_ovf"}, b_ovf, e.ovf);
                    check({e.tag, "_latency"}, cyc, e.due);
                    $display("B %s: out_data=%0h ovf=%0b cycle=%0d", e.tag, b_out_data, b_ovf, cyc);
                end
                b_seen = 1'b1;
            end
            if (b_out_ready) b_seen = 1'b0;
        end
    end

    task automatic drive_a(input logic [WA-1:0] d, input logic [1:0] m,
                           input logic [WA-1:0] ed, input logic eo, input bit push, input string tag);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_mode     = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_accept"}, ok, 1'b1);
        if (ok && push) qa.push_back('{64'(ed), eo, cyc + 1 + NA, tag});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic drive_b(input logic [WB-1:0] d, input logic [1:0] m,
                           input logic [WB-1:0] ed, input logic eo, input string tag);
        bit ok = 1'b0;
        @(posedge clk);
        #1;
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_mode     = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (b_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_accept"}, ok, 1'b1);
        if (ok) qb.push_back('{64'(ed), eo, cyc + 1 + NB, tag});
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        // Reset state, including across a clock edge while reset is held
        #3;
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("rst_out_data", a_out_data, 8'h00);
        check("rst_ovf", a_ovf, 1'b0);
        check("rst_in_ready_clk", a_in_ready, 1'b0);
        check("rst_b_in_ready", b_in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", a_in_ready, 1'b1);
        check("post_rst_b_in_ready", b_in_ready, 1'b1);

        // Directed vectors, 8-bit serial
        drive_a(8'h05, 2'b01, 8'hFB, 1'b0, 1, "neg_05");
        drive_a(8'h80, 2'b10, A_MINRES, 1'b1, 1, "abs_80");
        drive_a(8'hF6, 2'b10, 8'h0A, 1'b0, 1, "abs_F6");
        drive_a(8'h3C, 2'b11, 8'hC3, 1'b0, 1, "ones_3C");
        drive_a(8'h3C, 2'b00, 8'h3C, 1'b0, 1, "pass_3C");
        drive_a(8'h00, 2'b01, 8'h00, 1'b0, 1, "neg_00");
        drive_a(8'h80, 2'b01, A_MINRES, 1'b1, 1, "neg_80");
        drive_a(8'h80, 2'b00, 8'h80, 1'b0, 1, "pass_80");
        drive_a(8'h80, 2'b11, 8'h7F, 1'b0, 1, "ones_80");
        drive_a(8'h05, 2'b10, 8'h05, 1'b0, 1, "abs_05");
        drive_a(8'h7F, 2'b01, 8'h81, 1'b0, 1, "neg_7F");
        drive_a(8'hFF, 2'b01, 8'h01, 1'b0, 1, "neg_FF");

        // 16-bit, four bits per cycle
        drive_b(16'h0001, 2'b01, 16'hFFFF, 1'b0, "b_neg_0001");
        drive_b(16'h8000, 2'b10, B_MINRES, 1'b1, "b_abs_8000");
        drive_b(16'h1234, 2'b11, 16'hEDCB, 1'b0, "b_ones_1234");
        drive_b(16'h1234, 2'b01, 16'hEDCC, 1'b0, "b_neg_1234");

        // Backpressure: result held, next operand waits for consumption
        a_out_ready = 1'b0;
        drive_a(8'h7F, 2'b10, 8'h7F, 1'b0, 1, "hold_abs_7F");
        a_in_valid = 1'b1;
        a_in_data  = 8'hF6;
        a_mode     = 2'b01;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (a_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("hold_valid_seen", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_still_valid", a_out_valid, 1'b1);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("hold_next_accept", ok, 1'b1);
        check("hold_accept_no_valid", a_out_valid, 1'b0);
        if (ok) qa.push_back('{64'(8'h0A), 1'b0, cyc + 1 + NA, "after_hold_neg_F6"});
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;

        // Reset during the 4th RUN cycle aborts the operation
        drive_a(8'h33, 2'b01, 8'hCD, 1'b0, 0, "abort_op");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", a_out_valid, 1'b0);
        check("abort_out_data", a_out_data, 8'h00);
        check("abort_ovf", a_ovf, 1'b0);
        check("abort_in_ready", a_in_ready, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", a_in_ready, 1'b1);
        repeat (NA + 2) @(negedge clk);
        check("abort_no_result", a_out_valid, 1'b0);
        drive_a(8'h81, 2'b10, 8'h7F, 1'b0, 1, "after_abort_abs_81");

        // Drain
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0 && !a_out_valid && !b_out_valid) break;
        end
        check("drain_a", qa.size(), 0);
        check("drain_b", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
